// File: rtl/mem_dump_tx_pkg.sv
// rtl/mem_dump_tx_pkg.sv - shared state encoding and sizing helpers for the result dumper
package mem_dump_tx_pkg;

    typedef enum logic [2:0] {IDLE, HDR, ACC, RD, RDW, SEND, WAIT, DONE} state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int bpw(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_dump_tx_byte_serializer.sv
// rtl/mem_dump_tx_byte_serializer.sv - emits a loaded word LSB byte first over tx_start/tx_done, with watchdog
module mem_dump_tx_byte_serializer
    import mem_dump_tx_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int TIMEOUT    = 2**20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic                              single,
    input  logic [bpw(WORD_WIDTH)*8-1:0]      word,
    input  logic                              tx_done,
    output logic                              tx_start,
    output logic [7:0]                        tx_data,
    output logic                              last_done,
    output logic                              expired
);

    localparam int BPW = bpw(WORD_WIDTH);
    localparam int SW  = BPW * 8;
    localparam int CW  = $clog2(BPW + 1);
    localparam int WW  = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [SW-1:0] shift;
    logic [CW-1:0] left;
    logic [WW-1:0] wdog;

    // tx_done wins over an expiring watchdog in the same cycle
    assign last_done = (state == WAIT) && tx_done && (left == CW'(1));
    assign expired   = (state == WAIT) && !tx_done && (wdog == WW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            left     <= '0;
            wdog     <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    shift <= word;
                    left  <= single ? CW'(1) : CW'(BPW);
                    state <= SEND;
                end
                SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= shift[7:0];
                    wdog     <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (left == CW'(1)) begin
                            state <= IDLE;
                        end else begin
                            shift <= shift >> 8;
                            left  <= left - 1'b1;
                            state <= SEND;
                        end
                    end else if (wdog == WW'(TIMEOUT)) begin
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - on halt, streams header, accumulator and a RAM window out through the UART
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int         WORD_WIDTH  = 16,
    parameter int         ADDR_LENGTH = 11,
    parameter int         DUMP_WORDS  = 8,
    parameter int         START_ADDR  = 0,
    parameter int         SEND_HEADER = 1,
    parameter logic [7:0] HEADER_BYTE = HEADER_DEFAULT,
    parameter int         TIMEOUT     = 2**20
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [WORD_WIDTH-1:0]  i_acc,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    output logic                   o_mem_rd,
    input  logic [WORD_WIDTH-1:0]  i_mem_data,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error
);

    localparam int SW = bpw(WORD_WIDTH) * 8;
    localparam int IW = (DUMP_WORDS < 1) ? 1 : $clog2(DUMP_WORDS + 1);

    state_t                state;
    logic                  start_q;
    logic [WORD_WIDTH-1:0] acc_q;
    logic [IW-1:0]         word_idx;
    logic                  hdr_phase;
    logic                  ser_load;
    logic                  ser_single;
    logic [SW-1:0]         ser_word;
    logic                  last_done;
    logic                  expired;

    always_comb begin
        ser_load   = (state == HDR) || (state == ACC) || (state == RDW);
        ser_single = (state == HDR);
        ser_word   = '0;
        case (state)
            HDR:     ser_word = SW'(HEADER_BYTE);
            ACC:     ser_word = SW'(acc_q);
            RDW:     ser_word = SW'(i_mem_data);
            default: ser_word = '0;
        endcase
    end

    mem_dump_tx_byte_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_ser (
        .clk       (i_clock),
        .rst       (i_reset),
        .load      (ser_load),
        .single    (ser_single),
        .word      (ser_word),
        .tx_done   (i_tx_done),
        .tx_start  (o_tx_start),
        .tx_data   (o_tx_data),
        .last_done (last_done),
        .expired   (expired)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            acc_q      <= '0;
            word_idx   <= '0;
            hdr_phase  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_mem_rd   <= 1'b0;
            o_mem_addr <= '0;
        end else begin
            start_q  <= i_start;
            o_done   <= 1'b0;
            o_mem_rd <= 1'b0;
            case (state)
                IDLE: if (i_start && !start_q) begin
                    acc_q    <= i_acc;
                    o_error  <= 1'b0;
                    word_idx <= '0;
                    o_busy   <= 1'b1;
                    state    <= (SEND_HEADER != 0) ? HDR : ACC;
                end
                HDR: begin
                    hdr_phase <= 1'b1;
                    state     <= SEND;
                end
                ACC: begin
                    hdr_phase <= 1'b0;
                    state     <= SEND;
                end
                RD:  state <= RDW;
                RDW: begin
                    word_idx <= word_idx + 1'b1;
                    state    <= SEND;
                end
                // SEND here means "serializer owns the UART"; it tells us how the item ended
                SEND: begin
                    if (expired) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else if (last_done) begin
                        if (hdr_phase) begin
                            state <= ACC;
                        end else if (word_idx != IW'(DUMP_WORDS)) begin
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= ADDR_LENGTH'(START_ADDR) + ADDR_LENGTH'(word_idx);
                            state      <= RD;
                        end else begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
